// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants for the divider
package alu_pkg;

  localparam int DATA_WIDTH = 8;

  // Quotient reported for a divide by zero; replicated to the operand width by users.
  localparam logic [DATA_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/subtractor_9bit.sv
// rtl/subtractor_9bit.sv - ripple-borrow trial subtractor for the restoring divider
module subtractor_9bit #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W:0] bw;

  assign bw[0] = 1'b0;

  // One full-subtractor cell per bit, borrow rippling from LSB to MSB.
  for (genvar i = 0; i < W; i++) begin : g_cell
    assign diff_o[i] = a_i[i] ^ b_i[i] ^ bw[i];
    assign bw[i+1]   = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bw[i]);
  end

  assign borrow_o = bw[W];

endmodule

// File: rtl/seq_divider_8bit.sv
// rtl/seq_divider_8bit.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider_8bit
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DIV0_Q    = {WIDTH{DIV0_QUOTIENT[0]}};

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] q_q, q_d;
  // Partial remainder: its (WIDTH+1)-th bit is always zero because R stays below
  // the divisor, so only the low WIDTH bits are stored.
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial;
  logic             sub_borrow_unused;

  // Trial subtract of the shifted remainder against the latched divisor. Since
  // R < divisor, the trial MSB already carries the sign, so the borrow is spare.
  subtractor_9bit #(
    .W (WIDTH + 1)
  ) u_sub (
    .a_i      ({r_q, q_q[WIDTH-1]}),
    .b_i      ({1'b0, divisor_q}),
    .diff_o   (trial),
    .borrow_o (sub_borrow_unused)
  );

  // Next-state logic: accept in IDLE, iterate in CALC, single-cycle DONE.
  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    q_d       = q_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (divisor == '0) begin
            divisor_d = divisor;
            q_d       = DIV0_Q;
            r_d       = dividend;
            dz_d      = 1'b1;
            state_d   = DONE;
          end else begin
            divisor_d = divisor;
            q_d       = dividend;
            r_d       = '0;
            dz_d      = 1'b0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      q_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      q_q       <= q_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      dz_q      <= dz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dz_q;

endmodule
